image_buffer: RTL and testbench
===============================

IMAGE_BUFFER -- requirements
Module: image_buffer

Interface
REQ-001 Parameter SIDE, default 64, meaning image side in pixels; frame is SIDE x SIDE pixels of 24 bits (R 23:16, G 15:8, B 7:0); only 64 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_valid  input  1  load stream: pixel present on s_data.
REQ-005 s_ready  output  1  load stream: buffer accepts pixel.
REQ-006 s_data  input  24  load stream pixel, raster order (row 0 col 0 first, col fastest).
REQ-007 row  input  6  pixel row selected by the processing block.
REQ-008 col  input  6  pixel column selected by the processing block.
REQ-009 in_pix  output  24  frame pixel at [row, col].
REQ-010 out_we  input  1  processing-block write enable.
REQ-011 out_pix  input  24  pixel written to [row, col] when out_we=1.
REQ-012 filter_done  input  1  processing block has finished all operations (level).
REQ-013 proc_rst_n  output  1  active-low reset to the processing block.
REQ-014 m_valid  output  1  dump stream: pixel present on m_data.
REQ-015 m_ready  input  1  dump stream: consumer accepts pixel.
REQ-016 m_data  output  24  dump stream pixel, raster order.
REQ-017 m_last  output  1  marks dump pixel [63, 63].
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Storage: single 4096 x 24-bit frame, indexed {row, col}; same array is read and written in place by the processing block.
REQ-020 FSM states: IDLE, LOAD, RUN, DUMP; transitions only as stated below.
REQ-021 IDLE: s_ready=1, m_valid=0, proc_rst_n=0; first accepted load pixel (s_valid & s_ready) is written to index 0 and moves FSM to LOAD with load counter = 1.
REQ-022 LOAD: s_ready=1; each cycle with s_valid=1 writes s_data to index = load counter and increments it; s_valid=0 cycles write nothing (stalls of any length are legal).
REQ-023 LOAD exit: the cycle that accepts index 4095 moves FSM to RUN; s_ready=0 from the next cycle.
REQ-024 RUN: proc_rst_n=1, s_ready=0, m_valid=0; in_pix = frame[{row, col}] combinationally, same cycle, no latency.
REQ-025 RUN write: on a rising edge with out_we=1, frame[{row, col}] <= out_pix; a read of the same address in that cycle returns the old value (write visible next cycle).
REQ-026 out_we is ignored outside RUN; frame is not modified by the processing block in IDLE, LOAD or DUMP.
REQ-027 RUN exit: filter_done=1 sampled on a rising edge moves FSM to DUMP with dump counter = 0; proc_rst_n=0 from that edge on, so the processing block restarts cleanly on the next frame.
REQ-028 DUMP: m_valid=1, m_data = frame[dump counter], m_last = (dump counter == 4095); m_data and m_last stable while m_valid & !m_ready.
REQ-029 DUMP advance: on m_valid & m_ready the counter increments; transfer with m_last=1 returns FSM to IDLE and m_valid=0 the next cycle.
REQ-030 Counters are 12 bits; no wrap occurs because each state exits on index 4095.
REQ-031 Frame contents are not cleared between frames; a new LOAD overwrites all 4096 entries.
REQ-032 s_valid during RUN or DUMP is ignored (s_ready=0, no write).

Reset
REQ-033 rst_n=0 asynchronously forces IDLE, counters 0, s_ready=1 after release, m_valid=0, m_last=0, proc_rst_n=0, busy=0.
REQ-034 Reset mid-LOAD, mid-RUN or mid-DUMP aborts the frame; frame array contents are undefined and not reset.
REQ-035 in_pix has no reset value; it always reflects the frame array at [row, col].

Verification
REQ-036 Load 4096 pixels value = index, s_valid continuous -> busy=1 after first, FSM in RUN after 4096th, proc_rst_n=1, in_pix at row=1 col=2 equals 24'h000042.
REQ-037 Load with s_valid toggling every other cycle -> exactly 4096 writes, pixel [63,63] = 24'h000FFF, RUN entered 8191 cycles after first acceptance.
REQ-038 In RUN drive row=5 col=7 out_we=1 out_pix=24'hABCDEF -> in_pix at same address shows old value that cycle, 24'hABCDEF next cycle.
REQ-039 Assert filter_done -> proc_rst_n=0 next edge, m_valid=1, m_data = frame[0]; m_ready held 0 for 10 cycles -> m_data unchanged.
REQ-040 Dump with m_ready random -> 4096 transfers in raster order, m_last only on 4096th, FSM in IDLE, s_ready=1 afterwards.
REQ-041 rst_n pulsed low mid-DUMP at index 100 -> m_valid=0 immediately, busy=0, next load starts at index 0.

Source files
------------

// File: rtl/image_buffer.sv
// image_buffer: single-frame pixel store that loads a stream, lets a processing block edit it in place, then dumps it.
module image_buffer #(
    parameter int SIDE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic [5:0]  row,
    input  logic [5:0]  col,
    output logic [23:0] in_pix,
    input  logic        out_we,
    input  logic [23:0] out_pix,
    input  logic        filter_done,
    output logic        proc_rst_n,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_last,
    output logic        busy
);
    localparam int N = SIDE * SIDE;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;
    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [23:0] frame_q [N];
    logic        last_idx, we;
    logic [11:0] waddr;
    logic [23:0] wdata;
    assign last_idx = cnt_q == 12'(N - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // One counter serves as load index and dump index; each state leaves on 4095.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (s_valid) begin
                state_d = LOAD;
                cnt_d   = 12'd1;
            end
            LOAD: if (s_valid) begin
                cnt_d   = cnt_q + 12'd1;
                state_d = last_idx ? RUN : LOAD;
            end
            RUN: if (filter_done) begin
                state_d = DUMP;
                cnt_d   = '0;
            end
            DUMP: if (m_ready) begin
                cnt_d   = last_idx ? 12'd0 : cnt_q + 12'd1;
                state_d = last_idx ? IDLE : DUMP;
            end
        endcase
    end
    always_comb begin
        s_ready    = state_q == IDLE || state_q == LOAD;
        proc_rst_n = state_q == RUN;
        m_valid    = state_q == DUMP;
        m_last     = state_q == DUMP && last_idx;
        busy       = state_q != IDLE;
        we         = (s_ready && s_valid) || (proc_rst_n && out_we);
        waddr      = proc_rst_n ? {row, col} : cnt_q;
        wdata      = proc_rst_n ? out_pix : s_data;
    end
    // Frame contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) frame_q[waddr] <= wdata;
    end
    assign in_pix = frame_q[{row, col}];
    assign m_data = frame_q[cnt_q];
endmodule

// File: tb/tb_image_buffer.sv
// tb_image_buffer: scoreboard bench for image_buffer load / run / dump / reset behaviour.
module tb_image_buffer;
    logic        clk = 0, rst_n = 0, s_valid = 0, out_we = 0, filter_done = 0, m_ready = 0;
    logic [23:0] s_data = 0, out_pix = 0;
    logic [5:0]  row = 0, col = 0;
    logic        s_ready, proc_rst_n, m_valid, m_last, busy;
    logic [23:0] in_pix, m_data;
    int          n_chk = 0, n_pass = 0, cyc;
    logic [23:0] model [4096];
    logic [23:0] exp_q [$];

    image_buffer #(.SIDE(64)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .row(row), .col(col), .in_pix(in_pix), .out_we(out_we), .out_pix(out_pix),
        .filter_done(filter_done), .proc_rst_n(proc_rst_n), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic load_frame(bit toggle, logic [23:0] mask, output int cycles);
        int idx = 0, k = 0;
        bit acc, busy_chk = 0;
        cycles = 0;
        while (idx < 4096 && k < 20000) begin
            @(negedge clk);
            if (idx == 1 && !busy_chk) begin
                check("busy_after_first", busy, 1);
                busy_chk = 1;
            end
            s_valid = toggle ? (k % 2 == 0) : 1'b1;
            s_data  = 24'(idx) ^ mask;
            acc     = s_valid && s_ready;
            @(posedge clk);
            if (idx > 0 || acc) cycles++;
            if (acc) begin
                model[idx] = s_data;
                idx++;
            end
            k++;
        end
        @(negedge clk);
        s_valid = 0;
        if (idx < 4096) check("load_timeout", idx, 4096);
    endtask

    task automatic start_dump();
        @(negedge clk);
        filter_done = 1;
        @(posedge clk);
        #1 check("proc_rst_n_drop", proc_rst_n, 0);
        @(negedge clk);
        filter_done = 0;
        check("dump_m_valid", m_valid, 1);
        check("dump_first", m_data, model[0]);
        check("dump_first_last", m_last, 0);
    endtask

    task automatic dump(int n, bit rnd);
        int got = 0, k = 0;
        logic [23:0] e;
        exp_q = {};
        for (int i = 0; i < 4096; i++) exp_q.push_back(model[i]);
        while (got < n && k < 40000) begin
            @(negedge clk);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                check("m_data", m_data, e);
                check("m_last", m_last, 32'(got == 4095));
                got++;
            end
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        m_ready = 0;
        if (got < n) check("dump_timeout", got, n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_proc_rst_n", proc_rst_n, 0);
        check("rst_m_last", m_last, 0);
        rst_n = 1;
        #1 check("rst_s_ready", s_ready, 1);
        load_frame(0, 24'h0, cyc);
        check("load_cycles", cyc, 4096);
        check("run_busy", busy, 1);
        check("run_proc_rst_n", proc_rst_n, 1);
        check("run_s_ready", s_ready, 0);
        check("run_m_valid", m_valid, 0);
        row = 1; col = 2;
        #1 check("in_pix_1_2", in_pix, 24'h000042);
        // Loads during RUN must be dropped.
        s_valid = 1; s_data = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        s_valid = 0;
        for (int i = 0; i < 8; i++) begin
            row = 6'($urandom); col = 6'($urandom);
            #1 check("in_pix_rand", in_pix, model[{row, col}]);
        end
        @(negedge clk);
        row = 5; col = 7; out_we = 1; out_pix = 24'hABCDEF;
        #1 check("wr_old", in_pix, model[{6'd5, 6'd7}]);
        @(negedge clk);
        out_we = 0;
        model[{6'd5, 6'd7}] = 24'hABCDEF;
        check("wr_new", in_pix, 24'hABCDEF);
        // Writes outside RUN must be ignored.
        row = 0; col = 0; out_pix = 24'h777777;
        start_dump();
        out_we = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_m_data", m_data, model[0]);
        end
        dump(4096, 1);
        out_we = 0;
        check("idle_busy", busy, 0);
        check("idle_s_ready", s_ready, 1);
        check("idle_m_valid", m_valid, 0);
        load_frame(1, 24'h0, cyc);
        check("toggle_cycles", cyc, 8191);
        check("toggle_run", proc_rst_n, 1);
        row = 63; col = 63;
        #1 check("in_pix_63_63", in_pix, 24'h000FFF);
        start_dump();
        dump(100, 0);
        #2 rst_n = 0;
        #1 check("abort_m_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_proc_rst_n", proc_rst_n, 0);
        @(negedge clk);
        rst_n = 1;
        load_frame(0, 24'h5A5A5A, cyc);
        check("reload_cycles", cyc, 4096);
        start_dump();
        dump(4096, 1);
        check("final_s_ready", s_ready, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
